// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the two handshakes of the receive buffer:
//   write side : in_done (one-cycle strobe), in_err, in_data from the UART receiver
//   read side  : rd_valid / rd_ready first-word-fall-through port, with rd_data and rd_err
// Modports:
//   master : the environment (receiver + consumer) that drives in_* and rd_ready
//   slave  : the FIFO, which drives rd_valid / rd_data / rd_err
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              in_done;
    logic              in_err;
    logic [DATA_W-1:0] in_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    modport master (
        output in_done, in_err, in_data, rd_ready,
        input  rd_valid, rd_data, rd_err
    );

    modport slave (
        input  in_done, in_err, in_data, rd_ready,
        output rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side circular buffer placed right after the UART receiver. Each
// in_done pulse captures {in_err, in_data}; entries are presented on a
// first-word-fall-through valid/ready read port.
// Ports:
//   clk, rstN     : clock, synchronous active-low reset
//   bus (slave)   : in_done/in_err/in_data write strobe, rd_valid/rd_ready/
//                   rd_data/rd_err read port
//   clr_ovf       : clears the sticky overflow flag
//   flush         : discards all stored entries (overflow is kept)
//   level         : number of stored entries, 0..DEPTH
//   full, empty   : level == DEPTH / level == 0
//   overflow      : sticky, a byte arrived while full with no pop
//   thresh_irq    : level >= THRESH
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int THRESH = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    uart_rx_fifo_if.slave          bus,
    input  logic                   clr_ovf,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   thresh_irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Storage holds {err, data}; read is combinational so the head entry
    // falls through to rd_data without an extra cycle.
    logic [DATA_W:0]    mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;
    logic               drop;

    // Status flags decode only from the level register, never from inputs.
    assign full       = (level_q == LVL_W'(DEPTH));
    assign empty      = (level_q == '0);
    assign thresh_irq = (level_q >= LVL_W'(THRESH));
    assign level      = level_q;
    assign overflow   = overflow_q;

    assign bus.rd_valid = !empty;
    assign bus.rd_data  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.rd_err   = mem_q[rd_ptr_q][DATA_W];

    // Flush wins over both handshakes; a byte arriving during flush is lost
    // silently. A pop frees the slot, so a full FIFO still accepts a push in
    // the same cycle.
    assign pop  = bus.rd_valid & bus.rd_ready & ~flush;
    assign push = bus.in_done & (~full | pop) & ~flush;
    assign drop = bus.in_done & full & ~pop & ~flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        // A new drop takes priority over a clear in the same cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; contents are only observed behind rd_valid.
    always_ff @(posedge clk) begin
        if (rstN && push) begin
            mem_q[wr_ptr_q] <= {bus.in_err, bus.in_data};
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int THRESH = 8;

    logic       clk;
    logic       rstN;
    logic       clr_ovf;
    logic       flush;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       thresh_irq;

    int total;
    int bad;

    // Reference model: a plain queue of {err,data} plus the overflow bit.
    logic [8:0] mq[$];
    logic       m_ovf;

    uart_rx_fifo_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .THRESH(THRESH)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .bus       (bus),
        .clr_ovf   (clr_ovf),
        .flush     (flush),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .thresh_irq(thresh_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic d, input logic e, input logic [7:0] dat,
                         input logic rdy, input logic clr, input logic fl,
                         input logic rn);
        bit popped;
        bit dropped;
        int sz;
        popped  = 0;
        dropped = 0;
        if (!rn) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (fl) begin
                mq.delete();
            end else begin
                sz     = mq.size();
                popped = rdy && (sz > 0);
                if (popped) void'(mq.pop_front());
                if (d) begin
                    if (sz < DEPTH || popped) mq.push_back({e, dat});
                    else dropped = 1;
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".level"}, 32'(level), 32'(sz));
        chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(sz != 0));
        chk({tag, ".thresh"}, 32'(thresh_irq), 32'(sz >= THRESH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (sz > 0) begin
            chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(mq[0][7:0]));
            chk({tag, ".rd_err"}, 32'(bus.rd_err), 32'(mq[0][8]));
        end
    endtask

    // One clock: drive inputs, take the edge, update model, compare #1 later.
    task automatic step(input string tag, input logic d, input logic e,
                        input logic [7:0] dat, input logic rdy,
                        input logic clr, input logic fl, input logic rn);
        bus.in_done  = d;
        bus.in_err   = e;
        bus.in_data  = dat;
        bus.rd_ready = rdy;
        clr_ovf      = clr;
        flush        = fl;
        rstN         = rn;
        @(posedge clk);
        model(d, e, dat, rdy, clr, fl, rn);
        #1;
        check_state(tag);
        $display("step %s: in_done=%0b data=%02h rdy=%0b clr=%0b flush=%0b rstN=%0b -> level=%0d ovf=%0b head=%02h",
                 tag, d, dat, rdy, clr, fl, rn, level, overflow, bus.rd_data);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 8'h00, 0, 0, 0, 1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (mq.size() == 0) break;
            step(tag, 0, 0, 8'h00, 1, 0, 0, 1);
        end
        chk({tag, ".drained"}, 32'(empty), 32'd1);
    endtask

    initial begin
        logic [7:0] last;
        total = 0;
        bad   = 0;
        m_ovf = 1'b0;

        // Reset
        step("reset", 0, 0, 8'h00, 0, 0, 0, 0);
        step("reset", 0, 0, 8'h00, 0, 0, 0, 0);
        chk("reset.empty_const", 32'(empty), 32'd1);
        chk("reset.thresh_const", 32'(thresh_irq), 32'd0);

        // Two isolated pushes, then one pop
        step("push_a5", 1, 0, 8'hA5, 0, 0, 0, 1);
        idle("idle");
        step("push_3c", 1, 1, 8'h3C, 0, 0, 0, 1);
        idle("idle");
        chk("two.rd_data", 32'(bus.rd_data), 32'hA5);
        chk("two.level", 32'(level), 32'd2);
        step("pop1", 0, 0, 8'h00, 1, 0, 0, 1);
        chk("pop1.rd_data", 32'(bus.rd_data), 32'h3C);
        chk("pop1.rd_err", 32'(bus.rd_err), 32'd1);
        chk("pop1.level", 32'(level), 32'd1);
        drain("drain1");

        // Fill to full, drop one, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1, 0, 8'(i), 0, 0, 0, 1);
            chk("fill.thresh_const", 32'(thresh_irq), 32'(i + 1 >= 8));
        end
        chk("fill.full_const", 32'(full), 32'd1);
        step("drop_ff", 1, 0, 8'hFF, 0, 0, 0, 1);
        chk("drop.ovf_const", 32'(overflow), 32'd1);
        chk("drop.level_const", 32'(level), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(bus.rd_data), 32'(i));
            step("drain2", 0, 0, 8'h00, 1, 0, 0, 1);
        end
        chk("drain2.empty", 32'(empty), 32'd1);

        // Full with simultaneous push and pop
        step("clr", 0, 0, 8'h00, 0, 1, 0, 1);
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 8'(i), 0, 0, 0, 1);
        step("push_pop_full", 1, 0, 8'h77, 1, 0, 0, 1);
        chk("pp.level_const", 32'(level), 32'd16);
        chk("pp.ovf_const", 32'(overflow), 32'd0);
        chk("pp.head_const", 32'(bus.rd_data), 32'h01);
        last = 8'h00;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (!bus.rd_valid) break;
            last = bus.rd_data;
            step("drain3", 0, 0, 8'h00, 1, 0, 0, 1);
        end
        chk("pp.last_read", 32'(last), 32'h77);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            step("inter", ($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 1) != 0), 0, 0, 1);
            chk("inter.level_max", 32'(level <= 16), 32'd1);
        end
        drain("drain4");

        // Overflow set vs clear priority
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 8'(i + 16), 0, 0, 0, 1);
        step("drop", 1, 0, 8'hEE, 0, 0, 0, 1);
        step("drop_clr", 1, 0, 8'hDD, 0, 1, 0, 1);
        chk("dropclr.ovf_const", 32'(overflow), 32'd1);
        step("clr_only", 0, 0, 8'h00, 0, 1, 0, 1);
        chk("clr.ovf_const", 32'(overflow), 32'd0);

        // Flush with a concurrent write keeps overflow
        step("drop", 1, 0, 8'hCC, 0, 0, 0, 1);
        step("flush0", 0, 0, 8'h00, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step("push5", 1, 0, 8'(i + 8'h40), 0, 0, 0, 1);
        step("flush_push", 1, 0, 8'h11, 0, 0, 1, 1);
        chk("flush.level_const", 32'(level), 32'd0);
        chk("flush.valid_const", 32'(bus.rd_valid), 32'd0);
        chk("flush.ovf_const", 32'(overflow), 32'd1);

        // Mid-operation reset
        for (int i = 0; i < 3; i++) step("push3", 1, 0, 8'(i + 8'h50), 0, 0, 0, 1);
        step("rst_mid", 0, 0, 8'h00, 0, 0, 0, 0);
        chk("rst.level_const", 32'(level), 32'd0);
        chk("rst.ovf_const", 32'(overflow), 32'd0);

        // Random mix including clears and flushes
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) == 0), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
